// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module : pool_pkg
// Brief  : Shared types, mode constants and helpers for the 2-D pooling engine
// Rev    : 1.0  initial release
// ============================================================================
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Window sum of P*P signed N-bit values never overflows this width.
    function automatic int sum_w(input int n, input int p);
        return n + 2 * $clog2(p);
    endfunction

    function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] v,
                                                    input int n);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_qmul.sv
`default_nettype none
// ============================================================================
// Module : pool_qmul
// Brief  : Registered signed fixed-point multiply, round half up, saturate to N
// Rev    : 1.0  initial release
// ============================================================================
module pool_qmul
    import pool_pkg::*;
#(
    parameter int A_W = 16,
    parameter int N   = 16,
    parameter int Q   = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [A_W-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic signed [N-1:0] o_p
);

    localparam int PW = A_W + N;
    localparam logic signed [PW-1:0] c_HALF = PW'(64'sd1 <<< (Q - 1));

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_rnd;
    logic signed [N-1:0]  r_p;

    assign w_prod = PW'(i_a) * PW'(i_b);
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    assign w_rnd  = (w_prod + c_HALF) >>> Q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else begin
            r_p <= N'(sat_to_n(64'(w_rnd), N));
        end
    end

    assign o_p = r_p;

endmodule : pool_qmul
`default_nettype wire

// File: rtl/pool2d_stream.sv
`default_nettype none
// ============================================================================
// Module : pool2d_stream
// Brief  : Streaming PxP/stride-P max or average pooling over a raster feature
//          map. Define POOL_AVG_EN to build in the average path.
// Rev    : 1.0  initial release
// ============================================================================
module pool2d_stream
    import pool_pkg::*;
#(
    parameter int            N         = 16,
    parameter int            Q         = 12,
    parameter int            P         = 2,
    parameter int            M_MAX     = 64,
    parameter int            H_MAX     = 64,
    parameter logic [N-1:0]  P_SQR_INV = 16'h0400
) (
    input  logic                              clk,
    input  logic                              master_rst_n,
    input  logic                              start,
    input  logic [$clog2(M_MAX+1)-1:0]        cfg_width,
    input  logic [$clog2(H_MAX+1)-1:0]        cfg_height,
    input  logic                              cfg_mode,
    input  logic                              in_valid,
    input  logic signed [N-1:0]               data_in,
    output logic signed [N-1:0]               data_out,
    output logic                              valid_op,
    output logic                              end_op,
    output logic                              busy
);

    localparam int CW_W = $clog2(M_MAX + 1);
    localparam int CH_W = $clog2(H_MAX + 1);
    localparam int WW   = ($clog2(P) < 1) ? 1 : $clog2(P);
    localparam int RB_D = M_MAX / P;
    localparam int OC_W = (RB_D > 1) ? $clog2(RB_D) : 1;
`ifdef POOL_AVG_EN
    localparam int ACC_W = sum_w(N, P);
`else
    localparam int ACC_W = N;
`endif

    localparam logic [CW_W-1:0] c_WMAX  = CW_W'(M_MAX);
    localparam logic [CH_W-1:0] c_HMAX  = CH_W'(H_MAX);
    localparam logic [CW_W-1:0] c_ONE_W = CW_W'(1);
    localparam logic [CH_W-1:0] c_ONE_H = CH_W'(1);
    localparam logic [WW-1:0]   c_ONE_P = WW'(1);
    localparam logic [WW-1:0]   c_PM1   = WW'(P - 1);
    localparam logic [OC_W-1:0] c_ONE_O = OC_W'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW_W-1:0]         r_width, r_wlim, r_col;
    logic [CH_W-1:0]         r_height, r_hlim, r_row;
    logic [WW-1:0]           r_win_col, r_win_row;
    logic [OC_W-1:0]         r_out_col;
    logic                    r_mode;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_rowbuf [RB_D];
    logic                    r_s1_vld, r_s1_last;
    logic signed [ACC_W-1:0] r_s1_val;
    logic                    r_valid_op, r_end_op;
    logic signed [N-1:0]     r_max_q;

    logic                    w_cfg_ok, w_start, w_take, w_eol, w_last, w_in_win;
    logic                    w_wc_end, w_wr_end, w_is_max;
    logic signed [ACC_W-1:0] w_pix, w_row_val, w_win;

    function automatic logic signed [ACC_W-1:0] f_comb(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b,
                                                       input logic is_max);
        if (is_max) return (a > b) ? a : b;
        return a + b;
    endfunction

    assign w_cfg_ok = (cfg_width != '0) && (cfg_width <= c_WMAX) &&
                      (cfg_height != '0) && (cfg_height <= c_HMAX);
    assign w_start  = start && (r_state == ST_IDLE) && w_cfg_ok;
    assign w_take   = in_valid && (r_state == ST_RUN);
    assign w_eol    = (r_col == r_width - c_ONE_W);
    assign w_last   = w_take && w_eol && (r_row == r_height - c_ONE_H);
    // Trailing columns/rows past the last whole window are consumed silently.
    assign w_in_win = (r_col < r_wlim) && (r_row < r_hlim);
    assign w_wc_end = (r_win_col == c_PM1);
    assign w_wr_end = (r_win_row == c_PM1);
    assign w_is_max = (r_mode == MODE_MAX);

    assign w_pix     = ACC_W'(data_in);
    assign w_row_val = (r_win_col == '0) ? w_pix : f_comb(r_acc, w_pix, w_is_max);
    assign w_win     = (r_win_row == '0) ? w_row_val
                                         : f_comb(r_rowbuf[r_out_col], w_row_val, w_is_max);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start)  w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last)   w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_end_op) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_state    <= ST_IDLE;
            r_width    <= '0;
            r_wlim     <= '0;
            r_col      <= '0;
            r_height   <= '0;
            r_hlim     <= '0;
            r_row      <= '0;
            r_win_col  <= '0;
            r_win_row  <= '0;
            r_out_col  <= '0;
            r_mode     <= MODE_MAX;
            r_acc      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_val   <= '0;
            r_valid_op <= 1'b0;
            r_end_op   <= 1'b0;
            r_max_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_vld   <= 1'b0;
            r_s1_last  <= w_last;
            r_valid_op <= r_s1_vld;
            r_end_op   <= r_s1_last;
            if (r_s1_vld) r_max_q <= N'(r_s1_val);

            if (w_start) begin
                r_width   <= cfg_width;
                r_height  <= cfg_height;
                r_wlim    <= CW_W'((int'(cfg_width) / P) * P);
                r_hlim    <= CH_W'((int'(cfg_height) / P) * P);
`ifdef POOL_AVG_EN
                r_mode    <= cfg_mode;
`else
                r_mode    <= cfg_mode | MODE_MAX;
`endif
                r_col     <= '0;
                r_row     <= '0;
                r_win_col <= '0;
                r_win_row <= '0;
                r_out_col <= '0;
            end else if (w_take) begin
                if (w_eol) begin
                    r_col     <= '0;
                    r_win_col <= '0;
                    r_out_col <= '0;
                    r_row     <= r_row + c_ONE_H;
                    r_win_row <= w_wr_end ? '0 : r_win_row + c_ONE_P;
                end else begin
                    r_col <= r_col + c_ONE_W;
                    if (w_wc_end) begin
                        r_win_col <= '0;
                        r_out_col <= r_out_col + c_ONE_O;
                    end else begin
                        r_win_col <= r_win_col + c_ONE_P;
                    end
                end
                if (w_in_win) begin
                    r_acc <= w_row_val;
                    if (w_wc_end && w_wr_end) begin
                        r_s1_vld <= 1'b1;
                        r_s1_val <= w_win;
                    end
                end
            end
        end
    end

    // Row buffer needs no reset: each entry is loaded on win_row 0 before use.
    always_ff @(posedge clk) begin
        if (w_take && w_in_win && w_wc_end) begin
            r_rowbuf[r_out_col] <= w_win;
        end
    end

`ifdef POOL_AVG_EN
    logic signed [N-1:0] w_avg_q;

    pool_qmul #(
        .A_W (ACC_W),
        .N   (N),
        .Q   (Q)
    ) u_qmul (
        .clk   (clk),
        .rst_n (master_rst_n),
        .i_a   (r_s1_val),
        .i_b   (P_SQR_INV),
        .o_p   (w_avg_q)
    );

    assign data_out = w_is_max ? r_max_q : w_avg_q;
`else
    assign data_out = r_max_q;
`endif

    assign valid_op = r_valid_op;
    assign end_op   = r_end_op;
    assign busy     = (r_state != ST_IDLE);

endmodule : pool2d_stream
`default_nettype wire

// File: tb/tb_pool2d_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_pool2d_stream
// Brief  : Directed self-checking bench for pool2d_stream with a window model
// Rev    : 1.0  initial release
// ============================================================================
module tb_pool2d_stream;

    localparam int N  = 16;
    localparam int Q  = 12;
    localparam int P  = 2;
    localparam longint INV = 64'h0400;

    logic               clk;
    logic               master_rst_n;
    logic               start;
    logic [6:0]         cfg_width;
    logic [6:0]         cfg_height;
    logic               cfg_mode;
    logic               in_valid;
    logic signed [15:0] data_in;
    logic signed [15:0] data_out;
    logic               valid_op;
    logic               end_op;
    logic               busy;

    pool2d_stream dut (
        .clk          (clk),
        .master_rst_n (master_rst_n),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_mode     (cfg_mode),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .data_out     (data_out),
        .valid_op     (valid_op),
        .end_op       (end_op),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] val;
        int                 cyc;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] got;
        logic [31:0] exp;
    } chk_t;

    int                 cyc = 0;
    int                 exp_end = -1;
    int                 n_total = 0;
    int                 n_bad = 0;
    exp_t               exp_q[$];
    chk_t               chk_q[$];
    logic signed [15:0] got_q[$];
    logic signed [15:0] pix [0:7][0:7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic judge(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Sole checker: streams valid_op/end_op against the model and drains posted checks.
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        if (master_rst_n) begin
            if (valid_op) begin
                got_q.push_back(data_out);
                if (exp_q.size() == 0) begin
                    judge("spurious_valid_op", 32'(valid_op), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    judge("out_cycle", 32'(cyc), 32'(e.cyc));
                    judge("out_value", {16'h0, data_out}, {16'h0, e.val});
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                judge("missing_valid_op", 32'(valid_op), 32'd1);
                void'(exp_q.pop_front());
            end
            if (end_op) judge("end_op_cycle", 32'(cyc), 32'(exp_end));
            else if (cyc == exp_end) judge("end_op_missing", 32'(end_op), 32'd1);
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            judge(c.nm, c.got, c.exp);
        end
    end

    task automatic post(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_q.push_back('{nm, got, exp});
    endtask

    function automatic logic signed [15:0] win_val(input int r0, input int c0, input bit is_max);
        longint             s;
        longint             v;
        logic signed [15:0] m;
        s = 0;
        m = pix[r0][c0];
        for (int dr = 0; dr < P; dr++)
            for (int dc = 0; dc < P; dc++) begin
                s += longint'(pix[r0+dr][c0+dc]);
                if (pix[r0+dr][c0+dc] > m) m = pix[r0+dr][c0+dc];
            end
        if (is_max) return m;
        v = (s * INV + (64'sd1 <<< (Q - 1))) >>> Q;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    task automatic run_frame(input int w, input int h, input bit mode, input bit gaps,
                             input bit poke, input int abort_at);
        bit is_max;
        int n;
`ifdef POOL_AVG_EN
        is_max = mode;
`else
        is_max = 1'b1;
`endif
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 7'(w); cfg_height = 7'(h); cfg_mode = mode;
        in_valid = 1'b1; data_in = 16'sh7123;          // beat in IDLE must be dropped
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        post("busy_in_run", 32'(busy), 32'd1);
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (n == abort_at) begin
                    master_rst_n = 1'b0; in_valid = 1'b0;
                    exp_q.delete(); exp_end = -1;
                    @(negedge clk);
                    post("abort_data_out", {16'h0, data_out}, 32'd0);
                    post("abort_valid_op", 32'(valid_op), 32'd0);
                    post("abort_end_op", 32'(end_op), 32'd0);
                    post("abort_busy", 32'(busy), 32'd0);
                    @(negedge clk);
                    post("abort_valid_op_next", 32'(valid_op), 32'd0);
                    @(posedge clk); #1;
                    master_rst_n = 1'b1;
                    return;
                end
                if (gaps && (n % 3 == 1)) begin
                    in_valid = 1'b0; data_in = 16'sh7ABC;
                    @(posedge clk); #1;
                end
                in_valid = 1'b1; data_in = pix[r][c];
                if (poke && n == 1) begin
                    start = 1'b1; cfg_width = 7'd2; cfg_height = 7'd2;
                end
                if ((r % P == P - 1) && (c % P == P - 1) && (r < (h / P) * P) && (c < (w / P) * P))
                    exp_q.push_back('{win_val(r - P + 1, c - P + 1, is_max), cyc + 2});
                if (r == h - 1 && c == w - 1) exp_end = cyc + 2;
                n++;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (exp_end + 1 - cyc) @(posedge clk);
        @(negedge clk);
        post("busy_after_end", 32'(busy), 32'd0);
        post("model_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pin4(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        logic [15:0] want [4];
        want[0] = a; want[1] = b; want[2] = c; want[3] = d;
        post({nm, "_count"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            post($sformatf("%s_o%0d", nm, i),
                 (i < got_q.size()) ? {16'h0, got_q[i]} : 32'hDEAD_DEAD, {16'h0, want[i]});
    endtask

    task automatic bad_cfg(input string nm, input int w, input int h);
        @(posedge clk); #1;
        start = 1'b1; cfg_width = 7'(w); cfg_height = 7'(h); cfg_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        post(nm, 32'(busy), 32'd0);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix[r][c] = 16'(256 * (r * 4 + c));
    endtask

    initial begin
        master_rst_n = 1'b0; start = 1'b0; cfg_width = '0; cfg_height = '0;
        cfg_mode = 1'b0; in_valid = 1'b0; data_in = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pix[r][c] = '0;
        repeat (3) @(negedge clk);
        post("rst_data_out", {16'h0, data_out}, 32'd0);
        post("rst_valid_op", 32'(valid_op), 32'd0);
        post("rst_end_op", 32'(end_op), 32'd0);
        post("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        master_rst_n = 1'b1;

        fill_ramp();
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, -1);
        pin4("ramp_max", 16'h0500, 16'h0700, 16'h0D00, 16'h0F00);

        pix[0][0] = 16'h1000; pix[0][1] = 16'h1000; pix[1][0] = 16'h1000; pix[1][1] = 16'h1000;
        pix[0][2] = 16'h1000; pix[0][3] = 16'h2000; pix[1][2] = 16'h3000; pix[1][3] = 16'h4000;
        pix[2][0] = 16'hF000; pix[2][1] = 16'hE000; pix[3][0] = 16'hF800; pix[3][1] = 16'hD000;
        pix[2][2] = 16'h7FFF; pix[2][3] = 16'h7FFF; pix[3][2] = 16'h7FFF; pix[3][3] = 16'h7FFE;
        run_frame(4, 4, 1'b0, 1'b0, 1'b0, -1);
`ifdef POOL_AVG_EN
        pin4("avg_mix", 16'h1000, 16'h2800, 16'hE600, 16'h7FFF);
`else
        pin4("avg_mix", 16'h1000, 16'h4000, 16'hF800, 16'h7FFF);
`endif

        pix[0][0] = 16'hF000; pix[0][1] = 16'hE000; pix[1][0] = 16'hF800; pix[1][1] = 16'hD000;
        run_frame(2, 2, 1'b1, 1'b0, 1'b0, -1);
        post("neg_max_count", 32'(got_q.size()), 32'd1);
        post("neg_max_val", (got_q.size() > 0) ? {16'h0, got_q[0]} : 32'hDEAD_DEAD, 32'h0000_F800);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) pix[r][c] = 16'($urandom);
        run_frame(5, 5, 1'b1, 1'b1, 1'b0, -1);
        post("odd5_count", 32'(got_q.size()), 32'd4);
        run_frame(5, 5, 1'b0, 1'b1, 1'b0, -1);
        post("odd5_avg_count", 32'(got_q.size()), 32'd4);

        pix[0][0] = 16'h0111; pix[1][0] = 16'h0222; pix[2][0] = 16'h0333;
        run_frame(1, 3, 1'b1, 1'b0, 1'b1, -1);
        post("w1_count", 32'(got_q.size()), 32'd0);

        bad_cfg("cfg_w0_ignored", 0, 4);
        bad_cfg("cfg_w65_ignored", 65, 4);
        bad_cfg("cfg_h0_ignored", 4, 0);

        fill_ramp();
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, 6);
        fill_ramp();
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, -1);
        pin4("after_rst", 16'h0500, 16'h0700, 16'h0D00, 16'h0F00);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pool2d_stream
`default_nettype wire

// File: doc/pool2d_stream.md
# pool2d_stream

Streaming 2-D pooling engine for the CNN accelerator datapath; successor to the fixed-size pooler.
- Accepts a raster-ordered feature map one signed Q-format pixel per valid beat and emits one pooled value per P×P window, stride P.
- Image width/height and pooling mode are runtime-configurable, latched per frame.
- Sits between the convolution/activation stage and the output/next-layer buffer.

## Interface
- N, 16, data word width (signed two's complement, Q fractional bits)
- Q, 12, fractional bits
- P, 2, pool window size and stride (2..8)
- M_MAX, 64, maximum supported image width in pixels (multiple of P)
- H_MAX, 64, maximum supported image height
- P_SQR_INV, 16'h0400, 1/P² in (N,Q) format, used by average mode
- clk  input  1  clock, all state on rising edge
- master_rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; latches cfg_* and begins a frame
- cfg_width  input  clog2(M_MAX+1)  image width in pixels
- cfg_height  input  clog2(H_MAX+1)  image height in pixels
- cfg_mode  input  1  0 = average, 1 = max
- in_valid  input  1  data_in valid this cycle
- data_in  input  N  pixel
- data_out  output  N  pooled value
- valid_op  output  1  data_out valid (one-cycle pulse per output)
- end_op  output  1  one-cycle pulse: last output of frame (or frame done with none)
- busy  output  1  high from start until end_op

## Operation
- FSM: IDLE → RUN on start; RUN → FLUSH when last pixel (row cfg_height-1, col cfg_width-1) accepted; FLUSH → IDLE after pipeline empty (end_op cycle).
- start during RUN/FLUSH ignored; in_valid in IDLE/FLUSH ignored (pixel dropped).
- Counters: col (0..cfg_width-1), win_row (0..P-1), win_col (0..P-1), out_col, row; wrap at width/P boundaries.
- Horizontal reduce: window accumulator acc; first pixel of a window row loads acc, subsequent pixels combine (max: signed compare; avg: add).
- Vertical reduce: row buffer of M_MAX/P entries indexed by out_col; on win_row=0 the entry is loaded, else combined with acc. No comparison against zero reset values — negative maps pool correctly.
- Output when win_col=P-1 and win_row=P-1: combined value goes to output stage.
- Trailing columns (cfg_width mod P) and rows (cfg_height mod P) are consumed but produce no output (floor).
- Avg arithmetic: sum width N+2·clog2(P), no overflow; result = (sum·P_SQR_INV) >>> Q, round half toward +∞, saturate to signed N bits.
- cfg_width < P or cfg_height < P: no valid_op; end_op pulses 2 cycles after last pixel.
- cfg_width > M_MAX or 0, or cfg_height 0/> H_MAX: start ignored, stays IDLE.

## Timing
- Reset: data_out=0, valid_op=0, end_op=0, busy=0, FSM IDLE, counters 0; row buffer contents don't-care (always loaded before use).
- Latency: valid_op exactly 2 cycles after the in_valid beat completing a window, both modes (max path delayed to match multiplier stage).
- Back-to-back windows at full input rate supported; no backpressure, throughput 1 pixel/cycle.
- end_op coincides with final valid_op; busy drops the cycle after end_op.
- Next start accepted the cycle busy is low.
- Reset mid-frame: immediate abort, all outputs to reset values, no end_op.

## Configuration
- POOL_AVG_EN defined: average path (wide accumulator, multiplier, rounding, saturation) compiled in; cfg_mode honoured.
- Not defined: max-only; cfg_mode ignored, treated as 1; no multiplier; latency stays 2 cycles.

## Structure
- Package pool_pkg: state enum (IDLE, RUN, FLUSH), mode constants, SUM_W derivation, saturate-to-N function.
- Sub-module pool_qmul: signed N×N fixed-point multiply, registered, round + saturate; instantiated only under POOL_AVG_EN.
- Row buffer inferred as register array inside top.

## Test plan
- 4×4 max, P=2, pixels 0x0100·(r·4+c) → outputs 0x0500, 0x0700, 0x0D00, 0x0F00; end_op with 4th.
- Avg, four 0x1000 per window → 0x1000; window {0x1000,0x2000,0x3000,0x4000} → 0x2800.
- Max, all-negative window {0xF000,0xE000,0xF800,0xD000} → 0xF800 (no zero leakage).
- 5×5 image P=2 → exactly 4 outputs; trailing column/row dropped; gaps in in_valid don't change results.
- cfg_width=1: no valid_op, end_op 2 cycles after last pixel; start during RUN ignored.
- Reset asserted mid-frame → outputs zero immediately; new frame afterwards correct.
